// File: rtl/int_fp_mul_arb.sv
// Two-requester front end sharing one integer/FP16 multiplier through a
// 2-stage pipeline (S1 operands, S2 result) with valid/ready handshaking.

module int_fp_mul (
    input  logic        mode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        error
);
    logic [31:0] full_prod;
    logic [21:0] sig;
    logic [9:0]  mant;
    logic        guard;
    logic        sticky;
    logic [10:0] mant_r;
    logic [6:0]  exp_biased;
    logic [4:0]  exp_out;
    logic        sign;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    // FP16: subnormals flush to zero, round-to-nearest-even, error on any non-finite result
    always_comb begin
        result     = 16'h0000;
        error      = 1'b0;
        mant       = 10'h000;
        guard      = 1'b0;
        sticky     = 1'b0;
        full_prod  = {16'h0000, a} * {16'h0000, b};
        sig        = {11'h000, 1'b1, a[9:0]} * {11'h000, 1'b1, b[9:0]};
        sign       = a[15] ^ b[15];
        a_zero     = (a[14:10] == 5'd0);
        b_zero     = (b[14:10] == 5'd0);
        a_inf      = (a[14:10] == 5'd31) && (a[9:0] == 10'h000);
        b_inf      = (b[14:10] == 5'd31) && (b[9:0] == 10'h000);
        a_nan      = (a[14:10] == 5'd31) && (a[9:0] != 10'h000);
        b_nan      = (b[14:10] == 5'd31) && (b[9:0] != 10'h000);
        if (sig[21]) begin
            mant   = sig[20:11];
            guard  = sig[10];
            sticky = |sig[9:0];
        end else begin
            mant   = sig[19:10];
            guard  = sig[9];
            sticky = |sig[8:0];
        end
        mant_r     = {1'b0, mant} + {10'h000, guard & (sticky | mant[0])};
        exp_biased = {2'b00, a[14:10]} + {2'b00, b[14:10]} + {6'h00, sig[21]} + {6'h00, mant_r[10]};
        exp_out    = exp_biased[4:0] - 5'd15;

        if (!mode) begin
            result = full_prod[15:0];
            error  = |full_prod[31:16];
        end else if (a_nan || b_nan || ((a_inf || b_inf) && (a_zero || b_zero))) begin
            result = 16'h7E00;
            error  = 1'b1;
        end else if (a_inf || b_inf) begin
            result = {sign, 5'h1F, 10'h000};
            error  = 1'b1;
        end else if (a_zero || b_zero || exp_biased <= 7'd15) begin
            result = {sign, 15'h0000};
        end else if (exp_biased >= 7'd46) begin
            result = {sign, 5'h1F, 10'h000};
            error  = 1'b1;
        end else begin
            result = {sign, exp_out, mant_r[9:0]};
        end
    end
endmodule

module int_fp_mul_arb #(
    parameter int RR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_mode,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_mode,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_error,
    output logic [7:0]  err_cnt,
    output logic        busy
);
    logic        s1_valid_reg, s1_mode_reg, s1_id_reg;
    logic [15:0] s1_a_reg, s1_b_reg;
    logic        s2_valid_reg, s2_error_reg, s2_id_reg;
    logic [15:0] s2_result_reg;
    logic [7:0]  err_cnt_reg;
    logic        last_grant_reg;
    logic        hold_reg, hold_id_reg;
    logic        s1_ready, s2_ready;
    logic        grant_any, grant_id, accept;
    logic [15:0] mul_result;
    logic        mul_error;

    int_fp_mul u_mul (
        .mode   (s1_mode_reg),
        .a      (s1_a_reg),
        .b      (s1_b_reg),
        .result (mul_result),
        .error  (mul_error)
    );

    assign s2_ready = !s2_valid_reg || rsp_ready;
    assign s1_ready = !s1_valid_reg || s2_ready;

    // A grant that could not be accepted is pinned until that requester is taken
    always_comb begin
        grant_any = req0_valid || req1_valid;
        grant_id  = 1'b0;
        if (hold_reg && (hold_id_reg ? req1_valid : req0_valid))
            grant_id = hold_id_reg;
        else if (req0_valid && req1_valid)
            grant_id = (RR != 0) ? ~last_grant_reg : 1'b0;
        else
            grant_id = req1_valid;
    end

    assign accept     = grant_any && s1_ready && !rst;
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_mode_reg    <= 1'b0;
            s1_id_reg      <= 1'b0;
            s1_a_reg       <= 16'h0000;
            s1_b_reg       <= 16'h0000;
            s2_valid_reg   <= 1'b0;
            s2_result_reg  <= 16'h0000;
            s2_error_reg   <= 1'b0;
            s2_id_reg      <= 1'b0;
            err_cnt_reg    <= 8'h00;
            last_grant_reg <= 1'b1;
            hold_reg       <= 1'b0;
            hold_id_reg    <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid_reg <= accept;
                if (accept) begin
                    s1_id_reg   <= grant_id;
                    s1_mode_reg <= grant_id ? req1_mode : req0_mode;
                    s1_a_reg    <= grant_id ? req1_a : req0_a;
                    s1_b_reg    <= grant_id ? req1_b : req0_b;
                end
            end
            if (s2_ready) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    s2_result_reg <= mul_result;
                    s2_error_reg  <= mul_error;
                    s2_id_reg     <= s1_id_reg;
                end
            end
            if (accept)
                last_grant_reg <= grant_id;
            if (s2_valid_reg && rsp_ready && s2_error_reg && err_cnt_reg != 8'hFF)
                err_cnt_reg <= err_cnt_reg + 8'h01;
            hold_reg    <= grant_any && !accept;
            hold_id_reg <= grant_id;
        end
    end

    assign rsp_valid  = s2_valid_reg;
    assign rsp_id     = s2_id_reg;
    assign rsp_result = s2_result_reg;
    assign rsp_error  = s2_error_reg;
    assign err_cnt    = err_cnt_reg;
    assign busy       = s1_valid_reg || s2_valid_reg;
endmodule

// File: tb/tb_int_fp_mul_arb.sv
// Directed bench for int_fp_mul_arb: single ops, contention, backpressure,
// error-count saturation and mid-operation reset.

module tb_int_fp_mul_arb;
    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_mode;
    logic [15:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_mode;
    logic [15:0] req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_error;
    logic [15:0] rsp_result;
    logic [7:0]  err_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int_fp_mul_arb #(.RR(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_mode(req0_mode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_mode(req1_mode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_error(rsp_error),
        .err_cnt(err_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_mode = 1'b0; req0_a = 16'h0; req0_b = 16'h0;
        req1_valid = 1'b0; req1_mode = 1'b0; req1_a = 16'h0; req1_b = 16'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
        check("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        check("rst_rsp_result", {16'b0, rsp_result}, 32'd0);
        check("rst_rsp_error", {31'b0, rsp_error}, 32'd0);
        check("rst_rsp_id", {31'b0, rsp_id}, 32'd0);
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic single(input string tag, input logic id, input logic mode,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_res, input logic exp_err);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (id) begin
            req1_valid = 1'b1; req1_mode = mode; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_mode = mode; req0_a = a; req0_b = b;
        end
        #1;
        check({tag, "_ready"}, {30'b0, req1_ready, req0_ready}, id ? 32'd2 : 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check({tag, "_lat1_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd1);
        @(negedge clk); #1;
        check({tag, "_valid"}, {31'b0, rsp_valid}, 32'd1);
        check({tag, "_id"}, {31'b0, rsp_id}, {31'b0, id});
        check({tag, "_result"}, {16'b0, rsp_result}, {16'b0, exp_res});
        check({tag, "_error"}, {31'b0, rsp_error}, {31'b0, exp_err});
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        idle_inputs();
        do_reset();

        // Single operations, FP16 and integer
        single("fp_2x3",      1'b0, 1'b1, 16'h4000, 16'h4200, 16'h4600, 1'b0);
        single("int_3x5",     1'b1, 1'b0, 16'h0003, 16'h0005, 16'h000F, 1'b0);
        single("fp_1x1",      1'b0, 1'b1, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0);
        single("fp_neg",      1'b1, 1'b1, 16'hC000, 16'h4200, 16'hC600, 1'b0);
        single("fp_1p5sq",    1'b0, 1'b1, 16'h3E00, 16'h3E00, 16'h4080, 1'b0);
        single("fp_rne_tie",  1'b1, 1'b1, 16'h3C01, 16'h3E00, 16'h3E02, 1'b0);
        single("fp_ovf",      1'b0, 1'b1, 16'h7800, 16'h7800, 16'h7C00, 1'b1);
        single("fp_inf_zero", 1'b1, 1'b1, 16'h7C00, 16'h0000, 16'h7E00, 1'b1);
        single("fp_zero",     1'b0, 1'b1, 16'h0000, 16'h4200, 16'h0000, 1'b0);
        single("fp_undf",     1'b1, 1'b1, 16'h0400, 16'h0400, 16'h0000, 1'b0);
        single("int_max",     1'b0, 1'b0, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0);
        single("int_ovf",     1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b1);

        // Contention after reset: grants 0,1,0,1 and responses in the same order
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rsp_ready = 1'b1;
            req0_valid = (c < 4); req0_mode = 1'b0; req0_a = 16'h0010; req0_b = 16'h0002;
            req1_valid = (c < 4); req1_mode = 1'b0; req1_a = 16'h0010; req1_b = 16'h0003;
            #1;
            if (c < 4) begin
                check($sformatf("rr_c%0d_req0_ready", c), {31'b0, req0_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("rr_c%0d_req1_ready", c), {31'b0, req1_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
            end
            if (c >= 2) begin
                check($sformatf("rr_c%0d_valid", c), {31'b0, rsp_valid}, 32'd1);
                check($sformatf("rr_c%0d_id", c), {31'b0, rsp_id}, ((c - 2) % 2 == 1) ? 32'd1 : 32'd0);
                check($sformatf("rr_c%0d_result", c), {16'b0, rsp_result}, ((c - 2) % 2 == 1) ? 32'h30 : 32'h20);
            end
        end

        // Backpressure: 3 ops from req0, rsp_ready low for 5 cycles, req1 joins mid-stall
        do_reset();
        begin
            logic [15:0] bp_res [4];
            logic        bp_id  [4];
            int idx0 = 0, n_rsp = 0, stall_acc = 0;
            bit r1_done = 0;
            bp_res = '{16'd7, 16'd14, 16'd21, 16'd4};
            bp_id  = '{1'b0, 1'b0, 1'b0, 1'b1};
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                rsp_ready  = (c >= 5);
                req0_valid = (idx0 < 3); req0_mode = 1'b0;
                req0_a = 16'(idx0 + 1); req0_b = 16'd7;
                req1_valid = (c >= 3) && !r1_done; req1_mode = 1'b0;
                req1_a = 16'd2; req1_b = 16'd2;
                #1;
                if (req0_ready && req1_ready)
                    check("bp_both_ready", 32'd1, 32'd0);
                if (c >= 2 && c <= 4) begin
                    check($sformatf("bp_stall%0d_valid", c), {31'b0, rsp_valid}, 32'd1);
                    check($sformatf("bp_stall%0d_result", c), {16'b0, rsp_result}, 32'd7);
                    check($sformatf("bp_stall%0d_id", c), {31'b0, rsp_id}, 32'd0);
                    check($sformatf("bp_stall%0d_error", c), {31'b0, rsp_error}, 32'd0);
                end
                if (rsp_valid && rsp_ready) begin
                    if (n_rsp < 4) begin
                        check($sformatf("bp_rsp%0d_result", n_rsp), {16'b0, rsp_result}, {16'b0, bp_res[n_rsp]});
                        check($sformatf("bp_rsp%0d_id", n_rsp), {31'b0, rsp_id}, {31'b0, bp_id[n_rsp]});
                    end
                    n_rsp++;
                end
                if (req0_ready) begin
                    idx0++;
                    if (c < 5) stall_acc++;
                end
                if (req1_ready) r1_done = 1;
            end
            check("bp_accepted_during_stall", stall_acc, 32'd2);
            check("bp_rsp_count", n_rsp, 32'd4);
        end

        // Error counting: a stalled error response counts once; 300 errors saturate
        do_reset();
        begin
            int issued = 0, delivered = 0;
            rsp_ready = 1'b0;
            @(negedge clk);
            req0_valid = 1'b1; req0_mode = 1'b0; req0_a = 16'h0100; req0_b = 16'h0100;
            #1;
            check("err_first_ready", {31'b0, req0_ready}, 32'd1);
            issued = 1;
            @(negedge clk);
            idle_inputs();
            repeat (3) @(negedge clk);
            #1;
            check("err_stall_valid", {31'b0, rsp_valid}, 32'd1);
            check("err_stall_error", {31'b0, rsp_error}, 32'd1);
            check("err_stall_cnt", {24'b0, err_cnt}, 32'd0);
            @(negedge clk);
            rsp_ready = 1'b1;
            @(negedge clk); #1;
            check("err_once_cnt", {24'b0, err_cnt}, 32'd1);
            check("err_once_valid", {31'b0, rsp_valid}, 32'd0);
            delivered = 1;
            for (int c = 0; c < 1000 && delivered < 300; c++) begin
                @(negedge clk);
                req0_valid = (issued < 300); req0_mode = 1'b0;
                req0_a = 16'h0100; req0_b = 16'h0100;
                #1;
                if (req0_ready) issued++;
                if (rsp_valid && rsp_ready) begin
                    check($sformatf("err_cnt_at%0d", delivered), {24'b0, err_cnt},
                          (delivered > 255) ? 32'd255 : delivered);
                    delivered++;
                end
            end
            @(negedge clk);
            idle_inputs();
            @(negedge clk); #1;
            check("err_delivered", delivered, 32'd300);
            check("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
            check("err_busy_end", {31'b0, busy}, 32'd0);
        end

        // Mid-operation reset discards in-flight work and restores arbitration
        @(negedge clk);
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_mode = 1'b1; req0_a = 16'h4000; req0_b = 16'h4200;
        @(negedge clk);
        req0_a = 16'h3C00;
        #1;
        check("mr_second_accept", {31'b0, req0_ready}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        check("mr_busy_before", {31'b0, busy}, 32'd1);
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b1;
        #1;
        check("mr_ready_in_rst", {31'b0, req0_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0; idle_inputs(); rsp_ready = 1'b1;
        #1;
        check("mr_busy", {31'b0, busy}, 32'd0);
        check("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("mr_err_cnt", {24'b0, err_cnt}, 32'd0);
        check("mr_rsp_result", {16'b0, rsp_result}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check($sformatf("mr_no_rsp%0d", c), {31'b0, rsp_valid}, 32'd0);
        end
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("mr_contest_req0", {31'b0, req0_ready}, 32'd1);
        check("mr_contest_req1", {31'b0, req1_ready}, 32'd0);
        @(negedge clk);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
